// File: rtl/pcpi_ext_pkg.sv
// pcpi_ext_pkg: RV32I field encodings, instruction classes, FSM states and decode helpers for the PCPI shift/load-store extension.
package pcpi_ext_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [2:0] F3_B     = 3'b000;
  localparam logic [2:0] F3_H     = 3'b001;
  localparam logic [2:0] F3_W     = 3'b010;
  localparam logic [2:0] F3_BU    = 3'b100;
  localparam logic [2:0] F3_HU    = 3'b101;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SR    = 3'b101;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_SRA   = 7'b0100000;
  typedef enum logic [1:0] {C_NONE, C_SHIFT, C_LOAD, C_STORE} insn_class_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MEM, S_DONE} state_e;
  function automatic insn_class_e decode_insn(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic en_sub,
                                              input logic en_shift);
    logic sh_ok, ld_ok, st_ok;
    sh_ok = en_shift & ((f3 == F3_SLL & f7 == F7_BASE) |
                        (f3 == F3_SR & (f7 == F7_BASE | f7 == F7_SRA)));
    ld_ok = f3 == F3_W | (en_sub & (f3 == F3_B | f3 == F3_H | f3 == F3_BU | f3 == F3_HU));
    st_ok = f3 == F3_W | (en_sub & (f3 == F3_B | f3 == F3_H));
    return ((op == OP_REG | op == OP_IMM) & sh_ok) ? C_SHIFT :
           (op == OP_LOAD & ld_ok)                 ? C_LOAD  :
           (op == OP_STORE & st_ok)                ? C_STORE : C_NONE;
  endfunction
  // I-type immediate for loads, S-type split immediate for stores
  function automatic logic [31:0] mem_imm(input logic is_store, input logic [11:0] hi,
                                          input logic [4:0] lo);
    return is_store ? {{20{hi[11]}}, hi[11:5], lo} : {{20{hi[11]}}, hi};
  endfunction
endpackage

// File: rtl/pcpi_ext_lane_align.sv
// pcpi_ext_lane_align: byte-lane strobes/data for stores, lane extract and extension for loads, misalignment flag.
module pcpi_ext_lane_align
  import pcpi_ext_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_ofs,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_mis
);
  logic [31:0] w_lane;
  always_comb begin
    w_lane  = i_rdata >> {i_ofs, 3'b000};
    o_wstrb = i_f3[1:0] == 2'b00 ? 4'b0001 << i_ofs :
              i_f3[1:0] == 2'b01 ? 4'b0011 << i_ofs : 4'b1111;
    o_wdata = i_f3[1:0] == 2'b00 ? {4{i_wdata[7:0]}} :
              i_f3[1:0] == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = i_f3[1:0] == 2'b00 ? {{24{~i_f3[2] & w_lane[7]}}, w_lane[7:0]} :
              i_f3[1:0] == 2'b01 ? {{16{~i_f3[2] & w_lane[15]}}, w_lane[15:0]} : w_lane;
    o_mis   = (i_f3[1:0] == 2'b01 & i_ofs[0]) | (i_f3[1:0] == 2'b10 & |i_ofs);
  end
endmodule

// File: rtl/pcpi_lsu_shift_ext.sv
// pcpi_lsu_shift_ext: PCPI co-processor for RV32I shifts and base loads/stores over a valid/ready memory port,
// with misalignment trapping and a bounded memory wait.
module pcpi_lsu_shift_ext
  import pcpi_ext_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int EN_SUBWORD     = 1,
  parameter int EN_SHIFT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcpi_valid_i,
  input  logic [31:0] pcpi_insn_i,
  input  logic [31:0] pcpi_rs1_i,
  input  logic [31:0] pcpi_rs2_i,
  output logic        pcpi_wr_o,
  output logic [31:0] pcpi_rd_o,
  output logic        pcpi_wait_o,
  output logic        pcpi_ready_o,
  output logic        pcpi_trap_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e        r_state, w_next;
  insn_class_e   r_cls, w_cls;
  logic [2:0]    r_f3;
  logic          r_sra, r_block, r_wr, r_trap;
  logic [4:0]    r_shamt;
  logic [31:0]   r_rs1, r_rs2, r_ea, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_claim, w_mis, w_tmo, w_ok, w_unused;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata, w_ld, w_shres;
  pcpi_ext_lane_align u_align (
    .i_f3   (r_f3),
    .i_ofs  (r_ea[1:0]),
    .i_wdata(r_rs2),
    .i_rdata(mem_rdata_i),
    .o_wstrb(w_wstrb),
    .o_wdata(w_wdata),
    .o_rdata(w_ld),
    .o_mis  (w_mis)
  );
  assign w_unused = ^pcpi_insn_i[19:15];
  assign w_cls    = decode_insn(pcpi_insn_i[6:0], pcpi_insn_i[14:12], pcpi_insn_i[31:25],
                                EN_SUBWORD != 0, EN_SHIFT != 0);
  // r_block forbids re-claiming an instruction the core is still holding after ready
  assign w_claim  = r_state == S_IDLE & pcpi_valid_i & ~r_block & w_cls != C_NONE;
  assign w_tmo    = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_ok     = ~w_mis & mem_ready_i;
  assign w_shres  = r_f3 == F3_SLL ? r_rs1 << r_shamt :
                    r_sra ? 32'($signed(r_rs1) >>> r_shamt) : r_rs1 >> r_shamt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_claim ? (w_cls == C_SHIFT ? S_SHIFT : S_MEM) : S_IDLE;
      S_SHIFT: w_next = S_DONE;
      S_MEM:   w_next = (w_mis | mem_ready_i | w_tmo) ? S_DONE : S_MEM;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cls   <= C_NONE;
      r_f3    <= '0;
      r_sra   <= 1'b0;
      r_shamt <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_ea    <= '0;
      r_rd    <= '0;
      r_wr    <= 1'b0;
      r_trap  <= 1'b0;
      r_block <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_block <= r_state == S_DONE | (r_block & pcpi_valid_i);
      if (w_claim) begin
        r_cls   <= w_cls;
        r_f3    <= pcpi_insn_i[14:12];
        r_sra   <= pcpi_insn_i[30];
        r_shamt <= pcpi_insn_i[5] ? pcpi_rs2_i[4:0] : pcpi_insn_i[24:20];
        r_rs1   <= pcpi_rs1_i;
        r_rs2   <= pcpi_rs2_i;
        r_ea    <= pcpi_rs1_i + mem_imm(w_cls == C_STORE, pcpi_insn_i[31:20], pcpi_insn_i[11:7]);
        r_cnt   <= '0;
      end
      if (mem_valid_o) r_cnt <= r_cnt + CW'(1);
      if (r_state == S_SHIFT) begin
        r_rd   <= w_shres;
        r_wr   <= 1'b1;
        r_trap <= 1'b0;
      end
      if (r_state == S_MEM & w_next == S_DONE) begin
        r_trap <= ~w_ok;
        r_wr   <= w_ok & r_cls == C_LOAD;
        r_rd   <= ~w_ok ? '0 : r_cls == C_LOAD ? w_ld : r_rd;
      end
    end
  end
  assign pcpi_wait_o  = r_state == S_SHIFT | r_state == S_MEM;
  assign pcpi_ready_o = r_state == S_DONE;
  assign pcpi_wr_o    = pcpi_ready_o & r_wr;
  assign pcpi_trap_o  = pcpi_ready_o & r_trap;
  assign pcpi_rd_o    = r_rd;
  assign mem_valid_o  = r_state == S_MEM & ~w_mis;
  assign mem_addr_o   = mem_valid_o ? {r_ea[31:2], 2'b00} : '0;
  assign mem_wstrb_o  = mem_valid_o & r_cls == C_STORE ? w_wstrb : '0;
  assign mem_wdata_o  = mem_valid_o & r_cls == C_STORE ? w_wdata : '0;
endmodule

// File: tb/tb_pcpi_lsu_shift_ext.sv
// tb_pcpi_lsu_shift_ext: directed vectors with a response scoreboard, a memory model that checks each request,
// and a monitor that checks every ready pulse against the queued expectation.
module tb_pcpi_lsu_shift_ext;
  typedef struct {logic trap; logic wr; logic chk_rd; logic [31:0] rd;} rsp_t;
  typedef struct {logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} req_t;
  logic clk = 0, rst = 1;
  logic pcpi_valid_i = 0;
  logic [31:0] pcpi_insn_i = 0, pcpi_rs1_i = 0, pcpi_rs2_i = 0;
  logic pcpi_wr_o, pcpi_wait_o, pcpi_ready_o, pcpi_trap_o, mem_valid_o;
  logic [31:0] pcpi_rd_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_wstrb_o;
  logic mem_ready_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic [31:0] mem [0:63];
  rsp_t q_rsp[$];
  req_t q_req[$];
  int total = 0, bad = 0, lat = 0, vcnt = 0;
  bit noresp = 0;
  pcpi_lsu_shift_ext #(.TIMEOUT_CYCLES(64), .EN_SUBWORD(1), .EN_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .pcpi_valid_i(pcpi_valid_i), .pcpi_insn_i(pcpi_insn_i),
    .pcpi_rs1_i(pcpi_rs1_i), .pcpi_rs2_i(pcpi_rs2_i), .pcpi_wr_o(pcpi_wr_o), .pcpi_rd_o(pcpi_rd_o),
    .pcpi_wait_o(pcpi_wait_o), .pcpi_ready_o(pcpi_ready_o), .pcpi_trap_o(pcpi_trap_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd2, op};
  endfunction
  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd3, 5'd1, f3, 5'd2, 7'b0110011};
  endfunction
  // monitor: every ready pulse must match the oldest queued response
  initial forever begin
    @(negedge clk);
    if (pcpi_ready_o) begin
      if (q_rsp.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: got ready=1 want no response");
      end else begin
        rsp_t e;
        e = q_rsp.pop_front();
        chk("rsp_trap", 32'(pcpi_trap_o), 32'(e.trap));
        chk("rsp_wr", 32'(pcpi_wr_o), 32'(e.wr));
        chk("rsp_wait_low", 32'(pcpi_wait_o), 32'd0);
        if (e.chk_rd) chk("rsp_rd", pcpi_rd_o, e.rd);
      end
    end
  end
  // memory model: checks the first cycle of each request, answers after lat cycles unless noresp
  initial begin
    bit busy;
    int wc;
    busy = 0; wc = 0;
    forever begin
      @(negedge clk);
      mem_ready_i = 0;
      if (mem_valid_o) begin
        if (!busy) begin
          busy = 1; wc = 0; vcnt = 0;
          if (q_req.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_mem_req: got addr=%h want no request", mem_addr_o);
          end else begin
            req_t r;
            r = q_req.pop_front();
            chk("req_addr", mem_addr_o, r.addr);
            chk("req_wstrb", 32'(mem_wstrb_o), 32'(r.wstrb));
            if (r.wstrb != 0) chk("req_wdata", mem_wdata_o, r.wdata);
          end
        end
        vcnt++;
        if (!noresp && wc >= lat) begin
          mem_ready_i = 1;
          if (mem_wstrb_o == 0) mem_rdata_i = mem[mem_addr_o[7:2]];
          else for (int b = 0; b < 4; b++)
            if (mem_wstrb_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
        end
        wc++;
      end else busy = 0;
    end
  end
  task automatic exp_mem(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    req_t r;
    r.addr = addr; r.wstrb = wstrb; r.wdata = wdata;
    q_req.push_back(r);
  endtask
  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic trap, input logic wr, input logic chk_rd, input logic [31:0] rd,
                       input int hold);
    rsp_t e;
    int n;
    e.trap = trap; e.wr = wr; e.chk_rd = chk_rd; e.rd = rd;
    q_rsp.push_back(e);
    pcpi_insn_i = insn; pcpi_rs1_i = rs1; pcpi_rs2_i = rs2; pcpi_valid_i = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pcpi_ready_o && n < 300);
    if (!pcpi_ready_o) begin
      total++; bad++;
      $display("FAIL ready_timeout: got no ready after %0d cycles want ready", n);
    end
    repeat (hold) begin
      @(negedge clk);
      chk("no_reissue_wait", 32'(pcpi_wait_o), 32'd0);
    end
    pcpi_valid_i = 0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 0;
    mem[16] = 32'h80AD_BEEF;
    mem[17] = 32'h1234_5678;
    mem[19] = 32'h8001_1234;
    mem[2]  = 32'h1122_3344;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(pcpi_ready_o), 0);
    chk("rst_wait", 32'(pcpi_wait_o), 0);
    chk("rst_wr", 32'(pcpi_wr_o), 0);
    chk("rst_trap", 32'(pcpi_trap_o), 0);
    chk("rst_rd", pcpi_rd_o, 0);
    chk("rst_mem_valid", 32'(mem_valid_o), 0);
    chk("rst_wstrb", 32'(mem_wstrb_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    rst = 0;
    @(negedge clk);
    // shifts
    issue(i_type({7'b0100000, 5'd4}, 3'b101, 7'b0010011), 32'hF000_0000, 0, 0, 1, 1, 32'hFF00_0000, 0);
    issue(r_type(7'b0, 3'b001), 32'h1, 32'h21, 0, 1, 1, 32'h2, 0);
    issue(r_type(7'b0, 3'b101), 32'h8000_0000, 31, 0, 1, 1, 32'h1, 0);
    issue(r_type(7'b0100000, 3'b101), 32'h8000_0000, 31, 0, 1, 1, 32'hFFFF_FFFF, 0);
    issue(i_type({7'b0, 5'd31}, 3'b001, 7'b0010011), 32'h3, 0, 0, 1, 1, 32'h8000_0000, 0);
    // loads
    exp_mem(32'h40, 0, 0);
    issue(i_type(12'd3, 3'b000, 7'b0000011), 32'h40, 0, 0, 1, 1, 32'hFFFF_FF80, 0);
    exp_mem(32'h40, 0, 0);
    issue(i_type(12'd3, 3'b100, 7'b0000011), 32'h40, 0, 0, 1, 1, 32'h0000_0080, 0);
    exp_mem(32'h4C, 0, 0);
    issue(i_type(12'hFFE, 3'b001, 7'b0000011), 32'h50, 0, 0, 1, 1, 32'hFFFF_8001, 0);
    exp_mem(32'h4C, 0, 0);
    issue(i_type(12'hFFE, 3'b101, 7'b0000011), 32'h50, 0, 0, 1, 1, 32'h0000_8001, 0);
    lat = 3;
    exp_mem(32'h44, 0, 0);
    issue(i_type(12'd0, 3'b010, 7'b0000011), 32'h44, 0, 0, 1, 1, 32'h1234_5678, 0);
    lat = 0;
    // stores
    exp_mem(32'h08, 4'b1100, 32'hCAFE_CAFE);
    issue(s_type(12'd2, 3'b001), 32'h08, 32'h1234_CAFE, 0, 0, 0, 0, 0);
    chk("sh_mem2", mem[2], 32'hCAFE_3344);
    exp_mem(32'h0C, 4'b0010, 32'hA5A5_A5A5);
    issue(s_type(12'd1, 3'b000), 32'h0C, 32'h0000_00A5, 0, 0, 0, 0, 0);
    chk("sb_mem3", mem[3], 32'h0000_A500);
    exp_mem(32'h10, 4'b1111, 32'hDEAD_BEEF);
    issue(s_type(12'd0, 3'b010), 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    chk("sw_mem4", mem[4], 32'hDEAD_BEEF);
    // misaligned: trap without any memory request
    issue(i_type(12'd2, 3'b010, 7'b0000011), 32'h40, 0, 1, 0, 1, 32'h0, 0);
    issue(i_type(12'd3, 3'b001, 7'b0000011), 32'h40, 0, 1, 0, 1, 32'h0, 0);
    issue(s_type(12'd1, 3'b010), 32'h10, 32'h5, 1, 0, 1, 32'h0, 0);
    // timeout
    noresp = 1;
    exp_mem(32'h44, 0, 0);
    issue(i_type(12'd0, 3'b010, 7'b0000011), 32'h44, 0, 1, 0, 1, 32'h0, 0);
    chk("timeout_valid_cycles", 32'(vcnt), 32'd64);
    // reset while waiting on memory
    exp_mem(32'h44, 0, 0);
    pcpi_insn_i = i_type(12'd0, 3'b010, 7'b0000011); pcpi_rs1_i = 32'h44; pcpi_valid_i = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid_o && n < 10);
    chk("rst_mid_valid_seen", 32'(mem_valid_o), 1);
    repeat (3) @(negedge clk);
    rst = 1; pcpi_valid_i = 0;
    @(negedge clk);
    chk("rst_mid_mem_valid", 32'(mem_valid_o), 0);
    chk("rst_mid_wait", 32'(pcpi_wait_o), 0);
    chk("rst_mid_ready", 32'(pcpi_ready_o), 0);
    rst = 0; noresp = 0;
    repeat (3) @(negedge clk);
    // held valid must not be re-claimed
    issue(r_type(7'b0, 3'b001), 32'h5, 32'h2, 0, 1, 1, 32'h14, 6);
    // unsupported instruction (ADD) is never claimed
    pcpi_insn_i = r_type(7'b0, 3'b000); pcpi_valid_i = 1;
    repeat (4) begin
      @(negedge clk);
      chk("unsupported_wait", 32'(pcpi_wait_o), 0);
    end
    pcpi_valid_i = 0;
    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", 32'(q_rsp.size()), 0);
    chk("req_queue_empty", 32'(q_req.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
